// File: rtl/drbg_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drbg_sync_pkg
// Purpose  : Shared types and constants for the DRBG sequence synchronizer
//            and its distance comparator.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package drbg_sync_pkg;

  // Default configuration values
  localparam int unsigned c_def_seq_w       = 32;
  localparam int unsigned c_def_ahead_tol   = 16;
  localparam int unsigned c_def_max_behind  = 4096;
  localparam int unsigned c_def_ack_timeout = 64;
  localparam int unsigned c_def_rst_cycles  = 4;

  // Synchronizer state encoding
  typedef logic [2:0] sync_state_t;

  localparam sync_state_t c_st_wait_init  = 3'd0;
  localparam sync_state_t c_st_locked     = 3'd1;
  localparam sync_state_t c_st_catch_req  = 3'd2;
  localparam sync_state_t c_st_catch_wait = 3'd3;
  localparam sync_state_t c_st_hold       = 3'd4;
  localparam sync_state_t c_st_drbg_rst   = 3'd5;
  localparam sync_state_t c_st_error      = 3'd6;

  // Classification of d = target - internal (signed, modular)
  typedef enum logic [2:0] {
    CLS_EQUAL      = 3'd0,
    CLS_BEHIND     = 3'd1,
    CLS_AHEAD      = 3'd2,
    CLS_FAR_AHEAD  = 3'd3,
    CLS_FAR_BEHIND = 3'd4
  } dist_class_t;

  // Where the synchronizer goes once a distance class has been evaluated
  function automatic sync_state_t f_route(input dist_class_t cls);
    sync_state_t st;
    case (cls)
      CLS_EQUAL:     st = c_st_locked;
      CLS_BEHIND:    st = c_st_catch_req;
      CLS_AHEAD:     st = c_st_hold;
      CLS_FAR_AHEAD: st = c_st_drbg_rst;
      default:       st = c_st_error;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drbg_seq_compare.sv
`default_nettype none
// ============================================================================
// Module   : drbg_seq_compare
// Purpose  : Combinational wrap-safe sequence distance and classification.
//            Shared with the encoder-side sequence checker.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module drbg_seq_compare
  import drbg_sync_pkg::*;
#(
  parameter int unsigned SEQ_W      = c_def_seq_w,
  parameter int unsigned AHEAD_TOL  = c_def_ahead_tol,
  parameter int unsigned MAX_BEHIND = c_def_max_behind
) (
  input  logic [SEQ_W-1:0] target,
  input  logic [SEQ_W-1:0] internal,
  output logic [SEQ_W-1:0] distance,
  output dist_class_t      dist_class
);

  localparam logic [SEQ_W-1:0] c_ahead_tol  = SEQ_W'(AHEAD_TOL);
  localparam logic [SEQ_W-1:0] c_max_behind = SEQ_W'(MAX_BEHIND);

  logic [SEQ_W-1:0] w_lag;

  // Classify the modular distance; a negative d is judged by its magnitude
  // (internal - target), so d = -2^(SEQ_W-1) lands in FAR_AHEAD.
  always_comb begin
    distance = target - internal;
    w_lag    = internal - target;
    if (distance == '0) begin
      dist_class = CLS_EQUAL;
    end else if (distance[SEQ_W-1]) begin
      dist_class = (w_lag <= c_ahead_tol) ? CLS_AHEAD : CLS_FAR_AHEAD;
    end else begin
      dist_class = (distance <= c_max_behind) ? CLS_BEHIND : CLS_FAR_BEHIND;
    end
  end

endmodule
`default_nettype wire

// File: rtl/drbg_seq_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : drbg_seq_synchronizer
// Purpose  : Aligns the hash_drbg reseed counter with the far-end sequence
//            number using hold, catch-up (req/ack with timeout) or DRBG reset.
//            Optional statistics counters enabled by DRBG_SYNC_STATS_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module drbg_seq_synchronizer
  import drbg_sync_pkg::*;
#(
  parameter int unsigned SEQ_W       = c_def_seq_w,
  parameter int unsigned AHEAD_TOL   = c_def_ahead_tol,
  parameter int unsigned MAX_BEHIND  = c_def_max_behind,
  parameter int unsigned ACK_TIMEOUT = c_def_ack_timeout,
  parameter int unsigned RST_CYCLES  = c_def_rst_cycles
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init_done,
  input  logic [SEQ_W-1:0] sequence_internal,
  input  logic [SEQ_W-1:0] sequence_external,
  input  logic             sequence_external_valid,
  input  logic             V,
  output logic             catch_up_mode,
  output logic             get_next_seed,
  output logic             reset_n_drbg,
  output logic             block_drbg_reseed,
  output logic             locked,
  output logic             sync_error
`ifdef DRBG_SYNC_STATS_EN
  ,
  output logic [15:0]      resync_count,
  output logic [15:0]      hold_count,
  output logic [SEQ_W-1:0] catchup_steps
`endif
);

  localparam int unsigned c_cnt_max = (ACK_TIMEOUT > RST_CYCLES) ? ACK_TIMEOUT : RST_CYCLES;
  localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_ack_last = c_cnt_w'(ACK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_rst_last = c_cnt_w'(RST_CYCLES - 1);

  sync_state_t       r_state;
  sync_state_t       w_state_next;
  logic [SEQ_W-1:0]  r_target;
  logic [SEQ_W-1:0]  r_latched;
  logic              r_pending;
  logic [c_cnt_w-1:0] r_cnt;
  logic              w_consume;
  logic              w_rearm;
  logic              w_ack;
  logic              w_state_change;
  logic [SEQ_W-1:0]  w_distance;
  dist_class_t       w_class;

  logic r_catch_up_mode;
  logic r_get_next_seed;
  logic r_reset_n_drbg;
  logic r_block_drbg_reseed;
  logic r_locked;
  logic r_sync_error;

  drbg_seq_compare #(
    .SEQ_W      (SEQ_W),
    .AHEAD_TOL  (AHEAD_TOL),
    .MAX_BEHIND (MAX_BEHIND)
  ) u_compare (
    .target     (r_target),
    .internal   (sequence_internal),
    .distance   (w_distance),
    .dist_class (w_class)
  );

  assign w_ack          = (sequence_internal != r_latched);
  assign w_state_change = (w_state_next != r_state);
  // Entering DRBG reset re-arms evaluation so the target is caught up from 0
  assign w_rearm        = (w_state_next == c_st_drbg_rst) && (r_state != c_st_drbg_rst);

  // Next-state decode; w_consume marks the cycle a pending target is evaluated
  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    case (r_state)
      c_st_wait_init: begin
        if (init_done) begin
          if (r_pending) begin
            w_consume    = 1'b1;
            w_state_next = f_route(w_class);
          end else begin
            w_state_next = c_st_locked;
          end
        end
      end
      c_st_locked, c_st_hold: begin
        if (r_pending) begin
          w_consume    = 1'b1;
          w_state_next = f_route(w_class);
        end
      end
      c_st_catch_req: begin
        w_state_next = c_st_catch_wait;
      end
      c_st_catch_wait: begin
        // The ack always wins over a timeout in the same cycle
        if (w_ack) begin
          w_consume    = 1'b1;
          w_state_next = (w_distance == '0) ? c_st_locked : f_route(w_class);
        end else if (r_cnt == c_ack_last) begin
          w_state_next = c_st_error;
        end
      end
      c_st_drbg_rst: begin
        if (r_cnt == c_rst_last) begin
          w_state_next = c_st_wait_init;
        end
      end
      c_st_error: begin
        // Only a distance inside the recoverable window leaves ERROR
        if (r_pending) begin
          w_consume = 1'b1;
          if ((w_class != CLS_FAR_AHEAD) && (w_class != CLS_FAR_BEHIND)) begin
            w_state_next = f_route(w_class);
          end
        end
      end
      default: begin
        w_state_next = c_st_wait_init;
      end
    endcase
  end

  // State, target capture, pending flag, ack latch and dwell counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_st_wait_init;
      r_target  <= '0;
      r_latched <= '0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= sequence_external_valid | w_rearm | (r_pending & ~w_consume);
      if (sequence_external_valid) begin
        r_target <= sequence_external - {{(SEQ_W-1){1'b0}}, V};
      end
      if (r_state == c_st_catch_req) begin
        r_latched <= sequence_internal;
      end
      if (w_state_change) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  // Moore outputs registered from the next state so reset values are all 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_catch_up_mode     <= 1'b0;
      r_get_next_seed     <= 1'b0;
      r_reset_n_drbg      <= 1'b0;
      r_block_drbg_reseed <= 1'b0;
      r_locked            <= 1'b0;
      r_sync_error        <= 1'b0;
    end else begin
      r_catch_up_mode     <= (w_state_next == c_st_catch_req) || (w_state_next == c_st_catch_wait);
      r_get_next_seed     <= (w_state_next == c_st_catch_req);
      r_reset_n_drbg      <= (w_state_next != c_st_drbg_rst);
      r_block_drbg_reseed <= (w_state_next == c_st_hold) || (w_state_next == c_st_error);
      r_locked            <= (w_state_next == c_st_locked);
      r_sync_error        <= r_sync_error | (w_state_next == c_st_error);
    end
  end

  assign catch_up_mode     = r_catch_up_mode;
  assign get_next_seed     = r_get_next_seed;
  assign reset_n_drbg      = r_reset_n_drbg;
  assign block_drbg_reseed = r_block_drbg_reseed;
  assign locked            = r_locked;
  assign sync_error        = r_sync_error;

`ifdef DRBG_SYNC_STATS_EN
  logic [15:0]      r_resync_count;
  logic [15:0]      r_hold_count;
  logic [SEQ_W-1:0] r_catchup_steps;

  // Saturating event counters, cleared only by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resync_count  <= '0;
      r_hold_count    <= '0;
      r_catchup_steps <= '0;
    end else begin
      if (w_rearm && (r_resync_count != '1)) begin
        r_resync_count <= r_resync_count + 16'd1;
      end
      if ((w_state_next == c_st_hold) && (r_state != c_st_hold) && (r_hold_count != '1)) begin
        r_hold_count <= r_hold_count + 16'd1;
      end
      if ((w_state_next == c_st_catch_req) && (r_catchup_steps != '1)) begin
        r_catchup_steps <= r_catchup_steps + SEQ_W'(1);
      end
    end
  end

  assign resync_count  = r_resync_count;
  assign hold_count    = r_hold_count;
  assign catchup_steps = r_catchup_steps;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drbg_seq_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_drbg_seq_synchronizer
// Purpose  : Self-checking bench for drbg_seq_synchronizer with a small
//            behavioural hash_drbg counter model and an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drbg_seq_synchronizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic [31:0] seq_int;
  logic [31:0] seq_ext;
  logic        valid;
  logic        v;
  logic        catch_up_mode;
  logic        get_next_seed;
  logic        reset_n_drbg;
  logic        block_drbg_reseed;
  logic        locked;
  logic        sync_error;
`ifdef DRBG_SYNC_STATS_EN
  logic [15:0] resync_count;
  logic [15:0] hold_count;
  logic [31:0] catchup_steps;
`endif

  always #5 clk = ~clk;

  drbg_seq_synchronizer #(
    .SEQ_W       (32),
    .AHEAD_TOL   (16),
    .MAX_BEHIND  (4096),
    .ACK_TIMEOUT (64),
    .RST_CYCLES  (4)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .init_done               (init_done),
    .sequence_internal       (seq_int),
    .sequence_external       (seq_ext),
    .sequence_external_valid (valid),
    .V                       (v),
    .catch_up_mode           (catch_up_mode),
    .get_next_seed           (get_next_seed),
    .reset_n_drbg            (reset_n_drbg),
    .block_drbg_reseed       (block_drbg_reseed),
    .locked                  (locked),
    .sync_error              (sync_error)
`ifdef DRBG_SYNC_STATS_EN
    ,
    .resync_count            (resync_count),
    .hold_count              (hold_count),
    .catchup_steps           (catchup_steps)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // DRBG counter model: advances two edges after a get_next_seed pulse, or on
  // an external next request unless reseeding is blocked.
  logic [31:0] ctr;
  logic [2:0]  init_cnt;
  logic        gns_d;
  logic        set_req = 1'b0;
  logic [31:0] set_val = '0;
  logic        freeze  = 1'b0;
  logic        ext_next = 1'b0;

  always @(posedge clk or negedge reset_n_drbg) begin
    if (!reset_n_drbg) begin
      ctr       <= '0;
      init_cnt  <= '0;
      init_done <= 1'b0;
      gns_d     <= 1'b0;
    end else begin
      gns_d <= get_next_seed;
      if (init_cnt != 3'd3) init_cnt <= init_cnt + 3'd1;
      else init_done <= 1'b1;
      if (set_req) ctr <= set_val;
      else if (!freeze && (gns_d || (ext_next && !block_drbg_reseed))) ctr <= ctr + 32'd1;
    end
  end
  assign seq_int = ctr;

  // Output monitor: pulse counting, pulse shape and DRBG-reset dwell
  int   pulse_cnt = 0;
  int   rst_low_cycles = 0;
  logic prev_gns = 1'b0;

  always @(negedge clk) begin
    if (get_next_seed) begin
      pulse_cnt++;
      check("pulse_in_catchup", {31'd0, catch_up_mode}, 32'd1);
      check("pulse_width", {31'd0, prev_gns}, 32'd0);
    end
    prev_gns = get_next_seed;
    if (reset_n && !reset_n_drbg) rst_low_cycles++;
  end

  typedef struct {
    int          pulses;
    logic [31:0] fin;
    logic        lck;
    logic        err;
    logic        blk;
    int          rst;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  task automatic run_case(input string tag, input logic do_set, input logic [31:0] start,
                          input logic [31:0] ext, input logic vv, input exp_t e, input int bound);
    int    base_p;
    int    base_r;
    logic  settled;
    exp_t  x;
    string t;
    if (do_set) begin
      set_val = start;
      set_req = 1'b1;
      @(negedge clk);
      set_req = 1'b0;
    end
    base_p = pulse_cnt;
    base_r = rst_low_cycles;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    seq_ext = ext;
    v       = vv;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    v     = 1'b0;
    repeat (2) @(negedge clk);
    settled = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if ((locked || block_drbg_reseed) && !catch_up_mode && reset_n_drbg) begin
        settled = 1'b1;
        break;
      end
      @(negedge clk);
    end
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, "_settle"}, {31'd0, settled}, 32'd1);
    check({t, "_pulses"}, pulse_cnt - base_p, x.pulses);
    check({t, "_internal"}, seq_int, x.fin);
    check({t, "_locked"}, {31'd0, locked}, {31'd0, x.lck});
    check({t, "_sync_error"}, {31'd0, sync_error}, {31'd0, x.err});
    check({t, "_block"}, {31'd0, block_drbg_reseed}, {31'd0, x.blk});
    check({t, "_rst_cycles"}, rst_low_cycles - base_r, x.rst);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    reset_n = 1'b0;
    seq_ext = '0;
    valid   = 1'b0;
    v       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_catch_up_mode", {31'd0, catch_up_mode}, 32'd0);
    check("rst_get_next_seed", {31'd0, get_next_seed}, 32'd0);
    check("rst_reset_n_drbg", {31'd0, reset_n_drbg}, 32'd0);
    check("rst_block", {31'd0, block_drbg_reseed}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_sync_error", {31'd0, sync_error}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_drbg_before_edge", {31'd0, reset_n_drbg}, 32'd0);
    @(negedge clk);
    check("rel_drbg_after_edge", {31'd0, reset_n_drbg}, 32'd1);
    check("wait_init_unlocked", {31'd0, locked}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (locked) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("init_locked", {31'd0, found}, 32'd1);

    // Catch-up with V=1: target 19 from 10
    run_case("catchup_v1", 1'b1, 32'd10, 32'd20, 1'b1, '{9, 32'd19, 1'b1, 1'b0, 1'b0, 0}, 200);
    // Wrap-around catch-up
    run_case("wrap", 1'b1, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0, '{4, 32'd2, 1'b1, 1'b0, 1'b0, 0}, 200);
    // Small ahead: hold and block external reseeds
    run_case("hold", 1'b1, 32'd100, 32'd99, 1'b0, '{0, 32'd100, 1'b0, 1'b0, 1'b1, 0}, 50);
    for (int i = 0; i < 60; i++) begin
      ext_next = ~ext_next;
      @(negedge clk);
    end
    ext_next = 1'b0;
    @(negedge clk);
    check("hold_counter_frozen", seq_int, 32'd100);
    run_case("hold_release", 1'b0, 32'd0, 32'd100, 1'b0, '{0, 32'd100, 1'b1, 1'b0, 1'b0, 0}, 50);
    // Far ahead: DRBG reset then catch-up from 0
    run_case("far_ahead", 1'b1, 32'd200, 32'd139, 1'b0, '{139, 32'd139, 1'b1, 1'b0, 1'b0, 4}, 3000);
    // d = -2^31 classified far ahead
    run_case("half_range", 1'b1, 32'h8000_0000, 32'd0, 1'b0, '{0, 32'd0, 1'b1, 1'b0, 1'b0, 4}, 200);
    // Far behind: straight to error
    run_case("far_behind", 1'b1, 32'd1000, 32'd6000, 1'b0, '{0, 32'd1000, 1'b0, 1'b1, 1'b1, 0}, 50);
    // Ack timeout with a frozen counter
    freeze = 1'b1;
    run_case("ack_timeout", 1'b1, 32'd50, 32'd55, 1'b0, '{1, 32'd50, 1'b0, 1'b1, 1'b1, 0}, 300);
    freeze = 1'b0;
    run_case("error_recover", 1'b0, 32'd0, 32'd50, 1'b0, '{0, 32'd50, 1'b1, 1'b1, 1'b0, 0}, 50);

    // Asynchronous reset in the middle of a catch-up wait
    set_val = 32'd1000;
    set_req = 1'b1;
    @(negedge clk);
    set_req = 1'b0;
    seq_ext = 32'd1100;
    valid   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (catch_up_mode && !get_next_seed) begin found = 1'b1; break; end
    end
    check("mid_catch_wait_reached", {31'd0, found}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_catch_up_mode", {31'd0, catch_up_mode}, 32'd0);
    check("async_get_next_seed", {31'd0, get_next_seed}, 32'd0);
    check("async_reset_n_drbg", {31'd0, reset_n_drbg}, 32'd0);
    check("async_block", {31'd0, block_drbg_reseed}, 32'd0);
    check("async_locked", {31'd0, locked}, 32'd0);
    check("async_sync_error", {31'd0, sync_error}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel2_drbg_before_edge", {31'd0, reset_n_drbg}, 32'd0);
    @(negedge clk);
    check("rel2_drbg_after_edge", {31'd0, reset_n_drbg}, 32'd1);
    check("rel2_sync_error", {31'd0, sync_error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
